// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared encodings and reset/trap vectors for the PC redirect controller.
package pc_redirect_ctrl_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_IMM = 2'b01;
  localparam logic [1:0] PCSRC_ALU = 2'b10;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

endpackage

// File: rtl/pc_redirect_ctrl_flush_timer.sv
// Down-counter that measures the kill window following an accepted redirect.
module pc_flush_timer #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic done
);

  localparam logic [1:0] LOAD_VAL = 2'(FLUSH_CYCLES - 1);

  logic [1:0] count_r;

  // Load on redirect, count down once per flush cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 2'd0;
    end else if (load) begin
      count_r <= LOAD_VAL;
    end else if (tick && (count_r != 2'd0)) begin
      count_r <= count_r - 2'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == 2'd1);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer with redirect, wrong-path kill and misaligned-target trap.
// Optional performance counters are enabled by defining PC_REDIRECT_PERF_EN.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [31:0] TRAP_VEC     = TRAP_VEC_DEF,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic [1:0]  ex_pc_src_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_imm_i,
  input  logic [31:0] ex_alu_i,
  output logic [31:0] pc_o,
  output logic        fetch_valid_o,
  output logic        kill_o,
  output logic        misalign_o,
  output logic [31:0] bad_addr_o,
  output logic [31:0] perf_br_o,
  output logic [31:0] perf_trap_o
);

  localparam bit FLUSH_EN = (FLUSH_CYCLES > 1);

  state_t      state_r, state_next_s;
  logic [31:0] pc_r, pc_next_s, target_s;
  logic        redirect_s, trap_s, flush_done_s;
  logic        misalign_r;
  logic [31:0] bad_addr_r;

  // Redirect decode and target selection
  always_comb begin
    target_s   = ex_pc_i + ex_imm_i;
    redirect_s = 1'b0;
    case (ex_pc_src_i)
      PCSRC_IMM: begin
        target_s   = ex_pc_i + ex_imm_i;
        redirect_s = (state_r == ST_RUN) && ex_valid_i;
      end
      PCSRC_ALU: begin
        target_s   = {ex_alu_i[31:1], 1'b0};
        redirect_s = (state_r == ST_RUN) && ex_valid_i;
      end
      default: begin
        target_s   = ex_pc_i + ex_imm_i;
        redirect_s = 1'b0;
      end
    endcase
    trap_s = redirect_s && target_s[1];
  end

  // Next-state and next-PC; a redirect overrides a stall
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    case (state_r)
      ST_BOOT: begin
        state_next_s = ST_RUN;
        pc_next_s    = RESET_PC;
      end
      ST_RUN: begin
        if (redirect_s) begin
          state_next_s = FLUSH_EN ? ST_FLUSH : ST_RUN;
          pc_next_s    = trap_s ? TRAP_VEC : target_s;
        end else begin
          state_next_s = ST_RUN;
          pc_next_s    = stall_i ? pc_r : pc_r + 32'd4;
        end
      end
      ST_FLUSH: begin
        state_next_s = flush_done_s ? ST_RUN : ST_FLUSH;
        pc_next_s    = stall_i ? pc_r : pc_r + 32'd4;
      end
      default: begin
        state_next_s = ST_BOOT;
        pc_next_s    = RESET_PC;
      end
    endcase
  end

  // State, PC and trap reporting registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_PC;
      misalign_r <= 1'b0;
      bad_addr_r <= 32'h0000_0000;
    end else begin
      state_r    <= state_next_s;
      pc_r       <= pc_next_s;
      misalign_r <= trap_s;
      bad_addr_r <= trap_s ? target_s : bad_addr_r;
    end
  end

  pc_flush_timer #(.FLUSH_CYCLES(FLUSH_CYCLES)) u_flush_timer (
    .clk  (clk),
    .rst  (rst),
    .load (redirect_s),
    .tick (state_r == ST_FLUSH),
    .done (flush_done_s)
  );

`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] perf_br_r, perf_trap_r;

  // Free-running event counters, wrap at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_r   <= 32'h0000_0000;
      perf_trap_r <= 32'h0000_0000;
    end else begin
      perf_br_r   <= redirect_s ? perf_br_r + 32'd1 : perf_br_r;
      perf_trap_r <= trap_s ? perf_trap_r + 32'd1 : perf_trap_r;
    end
  end

  assign perf_br_o   = perf_br_r;
  assign perf_trap_o = perf_trap_r;
`else
  assign perf_br_o   = 32'h0000_0000;
  assign perf_trap_o = 32'h0000_0000;
`endif

  assign pc_o          = pc_r;
  assign fetch_valid_o = (state_r != ST_BOOT);
  assign kill_o        = redirect_s || (state_r == ST_FLUSH);
  assign misalign_o    = misalign_r;
  assign bad_addr_o    = bad_addr_r;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Table-driven directed bench for pc_redirect_ctrl (FLUSH_CYCLES=2).
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, ex_valid_i;
  logic [1:0]  ex_pc_src_i;
  logic [31:0] ex_pc_i, ex_imm_i, ex_alu_i;
  logic [31:0] pc_o, bad_addr_o, perf_br_o, perf_trap_o;
  logic        fetch_valid_o, kill_o, misalign_o;

  int n_total = 0;
  int n_bad   = 0;

  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
    .ex_pc_src_i(ex_pc_src_i), .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i),
    .ex_alu_i(ex_alu_i), .pc_o(pc_o), .fetch_valid_o(fetch_valid_o),
    .kill_o(kill_o), .misalign_o(misalign_o), .bad_addr_o(bad_addr_o),
    .perf_br_o(perf_br_o), .perf_trap_o(perf_trap_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        valid;
    logic [1:0]  src;
    logic [31:0] epc;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] exp_pc;
    logic        exp_kill;
    logic        exp_mis;
    logic [31:0] exp_bad;
    logic        exp_fv;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic v, input logic [1:0] s,
                     input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                     input logic [31:0] epc_exp, input logic k, input logic m,
                     input logic [31:0] b, input logic fv);
    vec_t t;
    t.stall = st; t.valid = v; t.src = s; t.epc = p; t.imm = i; t.alu = a;
    t.exp_pc = epc_exp; t.exp_kill = k; t.exp_mis = m; t.exp_bad = b; t.exp_fv = fv;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic v, input logic [1:0] s,
                       input logic [31:0] p, input logic [31:0] i, input logic [31:0] a);
    stall_i = st; ex_valid_i = v; ex_pc_src_i = s;
    ex_pc_i = p; ex_imm_i = i; ex_alu_i = a;
  endtask

  logic [31:0] exp_br, exp_trap;

  initial begin
    // inputs: stall valid src epc imm alu | pc kill mis bad fv
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h0,    0,0,32'h0,0);    // c0 BOOT
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h0,    0,0,32'h0,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h4,    0,0,32'h0,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h8,    0,0,32'h0,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'hC,    0,0,32'h0,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h10,   0,0,32'h0,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h14,   0,0,32'h0,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h18,   0,0,32'h0,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h1C,   0,0,32'h0,1);
    add(0,1,2'b01,32'h18,32'h40,32'h0,      32'h20,   1,0,32'h0,1);    // c9 branch
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h58,   1,0,32'h0,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h5C,   0,0,32'h0,1);
    add(0,1,2'b10,32'h0,32'h0,32'h1233,     32'h60,   1,0,32'h0,1);    // c12 JALR misaligned
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h100,  1,1,32'h1232,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h104,  0,0,32'h1232,1);
    add(1,1,2'b10,32'h0,32'h0,32'h80,       32'h108,  1,0,32'h1232,1); // c15 stall+redirect
    add(1,0,2'b00,32'h0,32'h0,32'h0,        32'h80,   1,0,32'h1232,1);
    add(1,0,2'b00,32'h0,32'h0,32'h0,        32'h80,   0,0,32'h1232,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h80,   0,0,32'h1232,1);
    add(0,1,2'b01,32'h300,32'h100,32'h0,    32'h84,   1,0,32'h1232,1); // c19
    add(0,1,2'b01,32'h200,32'h0,32'h0,      32'h400,  1,0,32'h1232,1); // ignored in FLUSH
    add(0,1,2'b10,32'h0,32'h0,32'h500,      32'h404,  1,0,32'h1232,1); // first RUN after FLUSH
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h500,  1,0,32'h1232,1);
    add(0,1,2'b11,32'h0,32'h40,32'h44,      32'h504,  0,0,32'h1232,1); // reserved = seq
    add(0,0,2'b01,32'h0,32'h40,32'h0,       32'h508,  0,0,32'h1232,1); // not valid
    add(0,1,2'b01,32'hFFFF_FFF0,32'h20,32'h0,32'h50C, 1,0,32'h1232,1); // wrap
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h10,   1,0,32'h1232,1);
    add(0,0,2'b00,32'h0,32'h0,32'h0,        32'h14,   0,0,32'h1232,1);

    rst = 1'b1;
    drive(0,0,2'b00,32'h0,32'h0,32'h0);
    #3;
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_fv", {31'd0, fetch_valid_o}, 32'h0);
    chk("rst_kill", {31'd0, kill_o}, 32'h0);
    chk("rst_mis", {31'd0, misalign_o}, 32'h0);
    chk("rst_bad", bad_addr_o, 32'h0);
    chk("rst_perf_br", perf_br_o, 32'h0);
    chk("rst_perf_trap", perf_trap_o, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[n]) begin
      drive(vecs[n].stall, vecs[n].valid, vecs[n].src, vecs[n].epc, vecs[n].imm, vecs[n].alu);
      @(negedge clk);
      chk($sformatf("v%0d_pc", n), pc_o, vecs[n].exp_pc);
      chk($sformatf("v%0d_kill", n), {31'd0, kill_o}, {31'd0, vecs[n].exp_kill});
      chk($sformatf("v%0d_mis", n), {31'd0, misalign_o}, {31'd0, vecs[n].exp_mis});
      chk($sformatf("v%0d_bad", n), bad_addr_o, vecs[n].exp_bad);
      chk($sformatf("v%0d_fv", n), {31'd0, fetch_valid_o}, {31'd0, vecs[n].exp_fv});
      @(posedge clk); #1;
    end

    // Redirect, then reset asserted during the FLUSH cycle
    drive(0,1,2'b01,32'h0,32'h40,32'h0);
    @(negedge clk);
    chk("seq_redir_kill", {31'd0, kill_o}, 32'h1);
    @(posedge clk); #1;
    drive(0,0,2'b00,32'h0,32'h0,32'h0);
`ifdef PC_REDIRECT_PERF_EN
    exp_br = 32'd7; exp_trap = 32'd1;
`else
    exp_br = 32'd0; exp_trap = 32'd0;
`endif
    chk("seq_flush_pc", pc_o, 32'h40);
    chk("seq_flush_kill", {31'd0, kill_o}, 32'h1);
    chk("perf_br", perf_br_o, exp_br);
    chk("perf_trap", perf_trap_o, exp_trap);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_kill", {31'd0, kill_o}, 32'h0);
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_fv", {31'd0, fetch_valid_o}, 32'h0);
    chk("mid_rst_perf_br", perf_br_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_boot_pc", pc_o, 32'h0);
    chk("post_rst_boot_kill", {31'd0, kill_o}, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_run_pc", pc_o, 32'h4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequences the program counter for the pipelined RISC-V core. It accepts the resolved next-PC selection from the execute stage (sequential, PC+imm for taken branches and JAL, ALU result for JALR), updates the fetch PC, and squashes wrong-path instructions by asserting a pipeline kill for a configurable number of cycles. It also traps misaligned targets, and honours hazard stalls from the hazard unit.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned target
- FLUSH_CYCLES, 2, cycles kill_o stays high per redirect (1..3)

- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  hazard stall; hold PC
- ex_valid_i  in  1  EX-stage instruction is valid
- ex_pc_src_i  in  2  00 seq, 01 PC+imm, 10 ALU result, 11 reserved (treated as 00)
- ex_pc_i  in  32  PC of EX instruction
- ex_imm_i  in  32  sign-extended immediate
- ex_alu_i  in  32  ALU result (JALR target)
- pc_o  out  32  current fetch PC
- fetch_valid_o  out  1  fetch PC is meaningful
- kill_o  out  1  squash IF/ID and ID/EX registers at next edge
- misalign_o  out  1  one-cycle pulse on misaligned target
- bad_addr_o  out  32  last misaligned target
- perf_br_o  out  32  redirects counted
- perf_trap_o  out  32  traps counted

## Operation
- FSM states: BOOT, RUN, FLUSH.
- BOOT: entered on reset. pc_o=RESET_PC, fetch_valid_o=0. Unconditionally → RUN next cycle.
- RUN, no redirect: if !stall_i, pc_o ← pc_o+4 (mod 2^32). Otherwise hold.
- Redirect condition: state RUN ∧ ex_valid_i ∧ ex_pc_src_i∈{01,10}.
- Target:
  - 01: ex_pc_i+ex_imm_i (32-bit wrap).
  - 10: {ex_alu_i[31:1],1'b0}, with bit 0 cleared per JALR.
- Redirect behaviour:
  - Overrides stall_i.
  - kill_o=1 combinationally in the redirect cycle.
  - If target[1]=1: pc_o ← TRAP_VEC, misalign_o pulses next cycle, bad_addr_o ← target.
  - Otherwise pc_o ← target.
  - If FLUSH_CYCLES>1 → FLUSH with counter=FLUSH_CYCLES−1; else stay RUN.
- FLUSH: kill_o=1; ex_valid_i/ex_pc_src_i ignored (wrong-path). PC advances by 4 unless stall_i. Counter decrements; at 1 → RUN.
- Reset outputs: pc_o=RESET_PC, fetch_valid_o=0, kill_o=0, misalign_o=0, bad_addr_o=0, perf counters=0, state=BOOT.

## Timing
- Redirect latency: target appears on pc_o the cycle after the redirect is presented.
- kill_o is high in the redirect cycle plus FLUSH_CYCLES−1 following cycles.
- Back-to-back redirects: a second redirect presented during FLUSH is ignored. A redirect presented in the first RUN cycle after FLUSH is honoured.
- Stall and redirect in the same cycle: redirect wins; PC takes the target.
- Reset asserted mid-FLUSH: immediate return to BOOT; kill_o drops asynchronously.
- Counters wrap at 2^32 without saturation.

## Configuration
- PC_REDIRECT_PERF_EN defined:
  - perf_br_o increments on every accepted redirect.
  - perf_trap_o increments on every misaligned trap.
- PC_REDIRECT_PERF_EN undefined: both ports are tied to 32'h0 and no counter flops are synthesized.
- All other behaviour is identical either way.

## Structure
- Shared package/defines file: PC-source encodings (PCSRC_SEQ=2'b00, PCSRC_IMM=2'b01, PCSRC_ALU=2'b10) and FSM state encodings.
- RESET_PC and TRAP_VEC defaults also live in the shared defines.
- One natural sub-module: pc_flush_timer, a down-counter loaded with FLUSH_CYCLES−1 that reports done. The FSM and PC register stay in the top.

## Test plan
- Reset, release, no stall for 4 cycles → pc_o: 0 (BOOT, fetch_valid_o=0), 0, 4, 8, 12.
- RUN at pc_o=0x20, ex_pc_src_i=01, ex_pc_i=0x18, ex_imm_i=0x40 → kill_o high 2 cycles, pc_o=0x58 next cycle, then 0x5C.
- JALR with ex_alu_i=0x0000_1233 → pc_o=0x1232 → misalign_o pulse, pc_o=0x100, bad_addr_o=0x1232.
- stall_i=1 together with redirect to 0x80 → pc_o=0x80. Then stall_i=1 alone → pc_o holds 0x80.
- Redirect, then a valid redirect to 0x200 during FLUSH → ignored; pc_o continues target+4.
- Assert rst during FLUSH → kill_o=0 immediately, pc_o=RESET_PC. With PC_REDIRECT_PERF_EN, after 3 redirects and 1 trap: perf_br_o=3, perf_trap_o=1.
